// File: rtl/euclid_stream_init.sv
// Euclidean-array front end: buffers 2T syndromes and emits one R/Q/L/U init frame.
// Define EUC_INIT_PINGPONG_EN for two syndrome banks so loading overlaps emission.
module euclid_stream_init #(
  parameter int T     = 16,
  parameter int M     = 13,
  parameter int DEG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             syn_valid,
  input  logic [M-1:0]     syn_data,
  output logic             syn_ready,
  output logic [M-1:0]     Rout,
  output logic [M-1:0]     Qout,
  output logic [M-1:0]     Lout,
  output logic [M-1:0]     Uout,
  output logic             start,
  output logic [DEG_W-1:0] deg_Ro,
  output logic [DEG_W-1:0] deg_Qo,
  output logic             stop_o,
  output logic             busy
);

  localparam int N  = 2 * T;
  localparam int LW = $clog2(N);
  localparam int KW = $clog2(N + 1);

`ifdef EUC_INIT_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef enum logic { LD_IDLE, LD_LOAD } ld_state_t;
  typedef enum logic { EM_IDLE, EM_EMIT } em_state_t;

  ld_state_t        ld_state_reg;
  em_state_t        em_state_reg;
  logic [M-1:0]     bank_reg [2][N];
  logic [1:0]       pend_reg;
  logic [DEG_W-1:0] nz_reg [2];
  logic [1:0]       az_reg;
  logic             wr_ptr_reg, rd_ptr_reg, em_bank_reg;
  logic [LW-1:0]    ld_cnt_reg;
  logic [KW-1:0]    k_reg;
  logic [DEG_W-1:0] ld_nz_reg;
  logic             ld_az_reg;
  logic             run_reg;

  logic [M-1:0]     rout_reg, qout_reg, uout_reg;
  logic             start_reg, stop_reg;
  logic [DEG_W-1:0] deg_ro_reg, deg_qo_reg;

  logic             wr_free, accept, first_beat, beat_nz, done_now;
  logic [DEG_W-1:0] fin_nz, launch_nz;
  logic             fin_az, launch_az;
  logic             frame_end, can_launch, from_pend, from_load, launch;
  logic [LW-1:0]    q_idx;

  // The write bank is free unless it holds an unlaunched codeword or is being emitted.
  assign wr_free    = !pend_reg[wr_ptr_reg] &&
                      !(em_state_reg == EM_EMIT && em_bank_reg == wr_ptr_reg);
  assign syn_ready  = run_reg && wr_free;
  assign accept     = syn_valid && syn_ready;
  assign first_beat = (ld_state_reg == LD_IDLE);
  assign beat_nz    = (syn_data != '0);
  assign fin_nz     = beat_nz ? DEG_W'(ld_cnt_reg) : (first_beat ? '0 : ld_nz_reg);
  assign fin_az     = !beat_nz && (first_beat || ld_az_reg);
  assign done_now   = accept && (ld_cnt_reg == LW'(N - 1));

  assign frame_end  = (em_state_reg == EM_EMIT) && (k_reg == KW'(N));
  assign can_launch = (em_state_reg == EM_IDLE) || frame_end;
  assign from_pend  = pend_reg[rd_ptr_reg];
  assign from_load  = done_now && (wr_ptr_reg == rd_ptr_reg);
  assign launch     = can_launch && (from_pend || from_load);
  assign launch_nz  = from_pend ? nz_reg[rd_ptr_reg] : fin_nz;
  assign launch_az  = from_pend ? az_reg[rd_ptr_reg] : fin_az;
  assign q_idx      = LW'(N - 1) - k_reg[LW-1:0];

  assign Rout   = rout_reg;
  assign Qout   = qout_reg;
  assign Lout   = '0;
  assign Uout   = uout_reg;
  assign start  = start_reg;
  assign deg_Ro = deg_ro_reg;
  assign deg_Qo = deg_qo_reg;
  assign stop_o = stop_reg;
  assign busy   = (ld_state_reg == LD_LOAD) || (em_state_reg == EM_EMIT) || (|pend_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_reg[b][i] <= '0;
        end
      end
    end else if (accept) begin
      bank_reg[wr_ptr_reg][ld_cnt_reg] <= syn_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_reg <= LD_IDLE;
      ld_cnt_reg   <= '0;
      ld_nz_reg    <= '0;
      ld_az_reg    <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      run_reg      <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (accept) begin
        ld_nz_reg <= fin_nz;
        ld_az_reg <= fin_az;
        if (done_now) begin
          ld_state_reg <= LD_IDLE;
          ld_cnt_reg   <= '0;
          wr_ptr_reg   <= wr_ptr_reg ^ PP;
        end else begin
          ld_state_reg <= LD_LOAD;
          ld_cnt_reg   <= ld_cnt_reg + 1'b1;
        end
      end
    end
  end

  // A bank completed while the emitter is busy is parked with its degree summary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg <= '0;
      az_reg   <= '0;
      for (int b = 0; b < 2; b++) begin
        nz_reg[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (done_now && !(launch && from_load) && wr_ptr_reg == 1'(b)) begin
          pend_reg[b] <= 1'b1;
          nz_reg[b]   <= fin_nz;
          az_reg[b]   <= fin_az;
        end else if (launch && from_pend && rd_ptr_reg == 1'(b)) begin
          pend_reg[b] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_state_reg <= EM_IDLE;
      k_reg        <= '0;
      em_bank_reg  <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      rout_reg     <= '0;
      qout_reg     <= '0;
      uout_reg     <= '0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      deg_ro_reg   <= '0;
      deg_qo_reg   <= '0;
    end else if (launch) begin
      em_state_reg <= EM_EMIT;
      k_reg        <= '0;
      em_bank_reg  <= rd_ptr_reg;
      rd_ptr_reg   <= rd_ptr_reg ^ PP;
      rout_reg     <= M'(1);
      qout_reg     <= '0;
      uout_reg     <= '0;
      start_reg    <= 1'b1;
      stop_reg     <= launch_az;
      deg_ro_reg   <= DEG_W'(N);
      deg_qo_reg   <= launch_az ? '0 : launch_nz;
    end else if (em_state_reg == EM_EMIT && !frame_end) begin
      k_reg     <= k_reg + 1'b1;
      rout_reg  <= '0;
      qout_reg  <= bank_reg[em_bank_reg][q_idx];
      uout_reg  <= (k_reg == KW'(N - 1)) ? M'(1) : '0;
      start_reg <= 1'b0;
    end else begin
      em_state_reg <= EM_IDLE;
      k_reg        <= '0;
      rout_reg     <= '0;
      qout_reg     <= '0;
      uout_reg     <= '0;
      start_reg    <= 1'b0;
    end
  end

endmodule
